// File: rtl/lane_serializer.sv
// lane_serializer: captures four WIDTH-bit lane buses in one handshake and
// replays the enabled lanes, lowest index first, one beat per cycle on a
// single valid/ready output stream. Disabled lanes are skipped in zero cycles.
module lane_serializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [3:0]       lane_en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_lane,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_lane_q [4];
    logic [3:0]       r_mask_q;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_lane;
    logic             r_out_last;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_frame_count;

    logic [WIDTH-1:0] w_in_lanes [4];
    logic             w_accept;
    logic [1:0]       w_first_lane;
    logic             w_first_last;
    logic [1:0]       w_next_lane;
    logic             w_next_last;

    // Bits of a lane mask strictly above the given lane index.
    function automatic logic [3:0] f_above(input logic [1:0] lane);
        logic [3:0] m;
        m = 4'b1110 << lane;
        return m;
    endfunction

    // Index of the lowest set bit; callers only use it on non-empty masks.
    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // A lane is the frame's last one when no enabled lane lies above it.
    function automatic logic f_is_last(input logic [3:0] m, input logic [1:0] lane);
        return (m & f_above(lane)) == 4'b0000;
    endfunction

    assign w_in_lanes[0] = a;
    assign w_in_lanes[1] = b;
    assign w_in_lanes[2] = c;
    assign w_in_lanes[3] = d;

    assign w_accept     = in_valid && in_ready;
    assign w_first_lane = f_lowest(lane_en);
    assign w_first_last = f_is_last(lane_en, w_first_lane);
    assign w_next_lane  = f_lowest(r_mask_q & f_above(r_out_lane));
    assign w_next_last  = f_is_last(r_mask_q, w_next_lane);

    // Frame capture, lane sequencing and completed-frame counting.
    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_mask_q      <= 4'b0000;
            r_out_data    <= '0;
            r_out_lane    <= 2'd0;
            r_out_last    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_frame_count <= '0;
            // NOTE: the four-entry lane store is tiny, so it is cleared on
            // reset to keep every observable value deterministic.
            for (int i = 0; i < 4; i++) begin
                r_lane_q[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < 4; i++) begin
                            r_lane_q[i] <= w_in_lanes[i];
                        end
                        r_mask_q <= lane_en;
                        if (lane_en != 4'b0000) begin
                            r_state     <= ST_SEND;
                            r_out_valid <= 1'b1;
                            r_out_lane  <= w_first_lane;
                            r_out_data  <= w_in_lanes[w_first_lane];
                            r_out_last  <= w_first_last;
                        end
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state       <= ST_IDLE;
                            r_out_valid   <= 1'b0;
                            r_frame_count <= r_frame_count + CNT_W'(1);
                        end else begin
                            r_out_lane <= w_next_lane;
                            r_out_data <= r_lane_q[w_next_lane];
                            r_out_last <= w_next_last;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE) && !rst;
    assign out_data    = r_out_data;
    assign out_lane    = r_out_lane;
    assign out_last    = r_out_last;
    assign out_valid   = r_out_valid;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer: queue-based reference model,
// per-cycle compare, directed scenarios with literal expectations, then
// randomized traffic with random backpressure and occasional reset.
module tb_lane_serializer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a, b, c, d;
    logic [3:0]       lane_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_lane;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] frame_count;

    lane_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .lane_en    (lane_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of the beats still owed to the consumer.
    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       lane;
        logic             last;
    } beat_t;

    beat_t mq[$];
    int    m_cnt = 0;
    bit    chk_en = 0;

    function automatic logic [WIDTH-1:0] lane_val(input int i);
        case (i)
            0:       return a;
            1:       return b;
            2:       return c;
            default: return d;
        endcase
    endfunction

    // Model update on each rising edge from pre-edge inputs.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            bit busy;
            busy = (mq.size() != 0);
            if (busy && out_ready) begin
                if (mq[0].last) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                void'(mq.pop_front());
            end
            if (!busy && in_valid) begin
                int hi;
                hi = -1;
                for (int i = 0; i < 4; i++) if (lane_en[i]) hi = i;
                for (int i = 0; i < 4; i++) begin
                    if (lane_en[i]) begin
                        beat_t bt;
                        bt.data = lane_val(i);
                        bt.lane = 2'(i);
                        bt.last = (i == hi);
                        mq.push_back(bt);
                    end
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(!rst && mq.size() == 0));
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("frame_count", 32'(frame_count), 32'(m_cnt));
            if (mq.size() != 0) begin
                check("out_data", 32'(out_data), 32'(mq[0].data));
                check("out_lane", 32'(out_lane), 32'(mq[0].lane));
                check("out_last", 32'(out_last), 32'(mq[0].last));
            end
        end
    end

    logic [WIDTH-1:0] g_d [4];
    logic [1:0]       g_l [4];
    logic             g_t [4];
    int               g_c [4];

    task automatic send(input logic [3:0] en, input logic [WIDTH-1:0] va, vb, vc, vd);
        int waited;
        @(posedge clk); #1;
        a = va; b = vb; c = vc; d = vd;
        lane_en  = en;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        check("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Records handshaken beats until the last one; cycle 1 is the first
    // negedge after the accepting edge.
    task automatic collect(output int n);
        bit done;
        done = 0;
        n = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                g_d[n] = out_data;
                g_l[n] = out_lane;
                g_t[n] = out_last;
                g_c[n] = cyc;
                n++;
                if (out_last || n == 4) done = 1;
            end
        end
        check("collect_done", 32'(done), 32'd1);
    endtask

    task automatic check_beat(input string name, input int i, input int exp_d,
                              input int exp_l, input int exp_t, input int exp_c);
        check({name, "_data"}, 32'(g_d[i]), 32'(exp_d));
        check({name, "_lane"}, 32'(g_l[i]), 32'(exp_l));
        check({name, "_last"}, 32'(g_t[i]), 32'(exp_t));
        check({name, "_cycle"}, 32'(g_c[i]), 32'(exp_c));
    endtask

    initial begin
        int n;
        rst = 1'b1; a = '0; b = '0; c = '0; d = '0;
        lane_en = 4'b0000; in_valid = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_lane", 32'(out_lane), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        chk_en = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Full mask
        send(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4);
        collect(n);
        check("full_n", 32'(n), 32'd4);
        check_beat("full0", 0, 1, 0, 0, 1);
        check_beat("full1", 1, 2, 1, 0, 2);
        check_beat("full2", 2, 3, 2, 0, 3);
        check_beat("full3", 3, 4, 3, 1, 4);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd1);
        check("full_count", 32'(frame_count), 32'd1);

        // Sparse masks
        send(4'b1000, 4'd0, 4'd0, 4'd0, 4'hA);
        collect(n);
        check("sp8_n", 32'(n), 32'd1);
        check_beat("sp8", 0, 'hA, 3, 1, 1);
        send(4'b0101, 4'd5, 4'd9, 4'd6, 4'd9);
        collect(n);
        check("sp5_n", 32'(n), 32'd2);
        check_beat("sp5_0", 0, 5, 0, 0, 1);
        check_beat("sp5_1", 1, 6, 2, 1, 2);

        // Empty mask
        send(4'b0000, 4'd1, 4'd1, 4'd1, 4'd1);
        @(negedge clk);
        check("empty_valid", 32'(out_valid), 32'd0);
        check("empty_in_ready", 32'(in_ready), 32'd1);
        check("empty_count", 32'(frame_count), 32'd3);

        // Backpressure with lane inputs changing during the stall
        out_ready = 1'b0;
        send(4'b0011, 4'd9, 4'd3, 4'd0, 4'd0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'd9);
            check("bp_hold_lane", 32'(out_lane), 32'd0);
            check("bp_hold_last", 32'(out_last), 32'd0);
            @(posedge clk); #1;
            a = 4'($urandom); b = 4'($urandom);
        end
        out_ready = 1'b1;
        collect(n);
        check("bp_n", 32'(n), 32'd2);
        check_beat("bp0", 0, 9, 0, 0, 1);
        check_beat("bp1", 1, 3, 1, 1, 2);

        // Reset during the second beat of a four-lane frame
        send(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        check("mid_beat0", 32'(out_data), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_beat1", 32'(out_data), 32'd2);
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(frame_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(4'b0010, 4'd0, 4'd7, 4'd0, 4'd0);
        collect(n);
        check("after_rst_n", 32'(n), 32'd1);
        check_beat("after_rst", 0, 7, 1, 1, 1);

        // Counter wrap with CNT_W=4
        for (int k = 0; k < 14; k++) begin
            send(4'b0100, 4'd0, 4'd0, 4'(k), 4'd0);
            collect(n);
        end
        @(negedge clk);
        check("wrap_15", 32'(frame_count), 32'd15);
        send(4'b0100, 4'd0, 4'd0, 4'd3, 4'd0);
        collect(n);
        @(negedge clk);
        check("wrap_0", 32'(frame_count), 32'd0);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            a = 4'($urandom); b = 4'($urandom);
            c = 4'($urandom); d = 4'($urandom);
            lane_en   = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
